// File: rtl/readout_arbiter.sv
// -----------------------------------------------------------------------------
// readout_arbiter
//
// Round-robin scheduler that shares the single serial readout link between
// N_REQ channel readout paths (one memory/PISO readout chain per channel).
// For every grant the block emits a framing header, which is a start bit
// followed by the channel ID MSB first. It then forwards the granted
// requester's serial bitstream to the link until that requester pulses done.
// Each frame is followed by one GAP cycle and one IDLE cycle.
// Arbitration happens only in IDLE.
//
// Optional build macro:
//   WATCHDOG_EN - adds a PAYLOAD watchdog. A frame whose requester does not
//                 pulse done within TIMEOUT payload cycles is aborted through
//                 GAP, and timeout_err pulses for that GAP cycle. Without the
//                 macro, no counter is built, timeout_err is tied low, and a
//                 payload lasts until done.
//
// Parameters:
//   N_REQ   - number of requesters (2..16)
//   ID_W    - channel ID width in the header (2**ID_W >= N_REQ)
//   TIMEOUT - watchdog limit in payload cycles (WATCHDOG_EN only)
//   TO_W    - watchdog counter width (2**TO_W > TIMEOUT)
//
// Ports:
//   clk          in   serial readout clock
//   reset        in   asynchronous, active-high reset
//   req          in   level request per channel, held while data is pending
//   done         in   one-cycle pulse from the granted requester; last bit
//   ser_in       in   serial data bit from each requester's output mux
//   grant        out  one-hot grant, high only in PAYLOAD
//   grant_id     out  index of the current/last granted channel
//   serial_out   out  shared serial link (combinational from ser_in in PAYLOAD)
//   sending      out  high during HEADER and PAYLOAD
//   frame_start  out  one-cycle pulse on the first HEADER cycle
//   timeout_err  out  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module readout_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [N_REQ-1:0] ser_in,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             serial_out,
    output logic             sending,
    output logic             frame_start,
    output logic             timeout_err
);

    // Width of the header bit counter. It counts 0..ID_W.
    localparam int CNT_W = $clog2(ID_W + 1);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(ID_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
    localparam logic [N_REQ-1:0] REQ_ONE  = N_REQ'(1);

    // A configuration that cannot be built correctly elaborates the marker
    // block below, so it shows up in the hierarchy.
    localparam bit CFG_OK = ((2 ** ID_W) >= N_REQ) && ((2 ** TO_W) > TIMEOUT)
                            && (N_REQ >= 2) && (TIMEOUT >= 1);

    if (!CFG_OK) begin : g_cfg_invalid
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t           state_r;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  grant_id_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [ID_W:0]    hdr_sr_r;
    logic [N_REQ-1:0] grant_r;
    logic             sending_r;
    logic             frame_start_r;

    logic [N_REQ-1:0] ptr_mask_s;
    logic [N_REQ-1:0] hi_req_s;
    logic [ID_W-1:0]  winner_s;
    logic             req_any_s;
    logic             done_hit_s;

`ifdef WATCHDOG_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_err_r;
`endif

    // Index of the lowest set bit of vec. Returns 0 for an empty vector.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N_REQ-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            id = vec[j] ? ID_W'(j) : id;
        end
        return id;
    endfunction

    // Round-robin search: lowest requester at or above ptr, else wrap to lowest
    // overall. Masking by ptr avoids a modulo, so non-power-of-2 N_REQ works.
    assign ptr_mask_s = ~((REQ_ONE << ptr_r) - REQ_ONE);
    assign hi_req_s   = req & ptr_mask_s;
    assign req_any_s  = |req;
    assign winner_s   = (|hi_req_s) ? lowest_set(hi_req_s) : lowest_set(req);

    // Only the granted line's done counts; done on other lines is ignored.
    assign done_hit_s = done[grant_id_r];

    // Main FSM: state, header shift, round-robin pointer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            grant_id_r    <= '0;
            bit_cnt_r     <= '0;
            hdr_sr_r      <= '0;
            grant_r       <= '0;
            sending_r     <= 1'b0;
            frame_start_r <= 1'b0;
`ifdef WATCHDOG_EN
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            frame_start_r <= 1'b0;
`ifdef WATCHDOG_EN
            timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        grant_id_r    <= winner_s;
                        hdr_sr_r      <= {1'b1, winner_s};
                        bit_cnt_r     <= '0;
                        sending_r     <= 1'b1;
                        frame_start_r <= 1'b1;
                        state_r       <= ST_HEADER;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end

                ST_HEADER: begin
                    // Zero-fill, so the shifter is empty once the header ends.
                    hdr_sr_r <= {hdr_sr_r[ID_W-1:0], 1'b0};
                    if (bit_cnt_r == HDR_LAST) begin
                        grant_r <= REQ_ONE << grant_id_r;
`ifdef WATCHDOG_EN
                        to_cnt_r <= '0;
`endif
                        state_r <= ST_PAYLOAD;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end

                ST_PAYLOAD: begin
                    if (done_hit_s) begin
                        grant_r   <= '0;
                        sending_r <= 1'b0;
                        state_r   <= ST_GAP;
`ifdef WATCHDOG_EN
                    end else if (to_cnt_r == TO_LAST) begin
                        grant_r       <= '0;
                        sending_r     <= 1'b0;
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
`else
                    end else begin
                        state_r <= ST_PAYLOAD;
                    end
`endif
                end

                ST_GAP: begin
                    // The channel after the one just served gets first priority.
                    ptr_r   <= (grant_id_r == LAST_ID) ? '0 : grant_id_r + ID_ONE;
                    state_r <= ST_IDLE;
                end

                default: begin
                    grant_r   <= '0;
                    sending_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Link mux. Header bits come from the shifter and payload bits pass
    // straight from the granted ser_in. The link is low in IDLE and GAP.
    always_comb begin
        serial_out = 1'b0;
        case (state_r)
            ST_HEADER:  serial_out = hdr_sr_r[ID_W];
            ST_PAYLOAD: serial_out = ser_in[grant_id_r];
            default:    serial_out = 1'b0;
        endcase
    end

    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign sending     = sending_r;
    assign frame_start = frame_start_r;

`ifdef WATCHDOG_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_readout_arbiter
//
// Self-checking bench for readout_arbiter (N_REQ=4, ID_W=2, TIMEOUT=16).
// The reference model works at frame level. The next winner comes from a
// modular round-robin search over the request vector. Each frame is checked
// as an IDLE cycle, a start bit, the ID bits MSB first, the payload bits of
// the granted channel, and then a GAP cycle. Inputs change 2 ns after the
// rising edge, and outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_readout_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   ser_in;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           serial_out;
    logic           sending;
    logic           frame_start;
    logic           timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;

    readout_arbiter #(
        .N_REQ   (N),
        .ID_W    (IDW),
        .TIMEOUT (16),
        .TO_W    (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .ser_in      (ser_in),
        .grant       (grant),
        .grant_id    (grant_id),
        .serial_out  (serial_out),
        .sending     (sending),
        .frame_start (frame_start),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference round-robin choice: first requester at p, p+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One frame. mode 0 ends with done, mode 1 expects a watchdog abort, and
    // mode 2 applies reset mid-payload. spur injects done on the granted line
    // during the header and on a foreign line during the payload.
    task automatic run_frame(input logic [N-1:0] req_idle, input logic [N-1:0] req_pay,
                             input int pay_len, input int mode, input bit spur,
                             input logic [31:0] pat);
        int           id;
        logic [N-1:0] own;
        logic [N-1:0] other;
        logic [N-1:0] sv;

        tick();
        req    = req_idle;
        done   = 4'b0000;
        ser_in = 4'($urandom);
        id     = pick(req_idle, m_ptr);
        own    = 4'b0001 << id;
        other  = 4'b0001 << ((id + 1) % N);
        #3;
        chk("idle_sending", 32'(sending), 32'd0);
        chk("idle_serial", 32'(serial_out), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);

        tick();
        ser_in = 4'($urandom);
        #3;
        chk("hdr_frame_start", 32'(frame_start), 32'd1);
        chk("hdr_sending", 32'(sending), 32'd1);
        chk("hdr_start_bit", 32'(serial_out), 32'd1);
        chk("hdr_grant", 32'(grant), 32'd0);
        chk("hdr_grant_id", 32'(grant_id), 32'(id));

        for (int b = IDW - 1; b >= 0; b--) begin
            tick();
            ser_in = 4'($urandom);
            done   = (spur && b == IDW - 1) ? own : 4'b0000;
            #3;
            chk("hdr_id_bit", 32'(serial_out), 32'((id >> b) & 1));
            chk("hdr_fs_low", 32'(frame_start), 32'd0);
            chk("hdr_grant_low", 32'(grant), 32'd0);
            chk("hdr_sending_hi", 32'(sending), 32'd1);
        end

        for (int k = 0; k < pay_len; k++) begin
            tick();
            if (k == 0) req = req_pay;
            sv     = 4'($urandom);
            sv[id] = pat[k % 32];
            ser_in = sv;
            done   = ((mode == 0 && k == pay_len - 1) ? own : 4'b0000)
                   | ((spur && k == 0) ? other : 4'b0000);
            #3;
            chk("pay_grant", 32'(grant), 32'(own));
            chk("pay_serial", 32'(serial_out), 32'(pat[k % 32]));
            chk("pay_sending", 32'(sending), 32'd1);
            chk("pay_timeout_low", 32'(timeout_err), 32'd0);
            chk("pay_grant_id", 32'(grant_id), 32'(id));
        end

        if (mode == 2) begin
            tick();
            done   = 4'b0000;
            ser_in = 4'b1111;
            reset  = 1'b1;
            #1;
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd0);
            chk("rst_serial", 32'(serial_out), 32'd0);
            chk("rst_sending", 32'(sending), 32'd0);
            chk("rst_frame_start", 32'(frame_start), 32'd0);
            chk("rst_timeout", 32'(timeout_err), 32'd0);
            m_ptr = 0;
            req   = 4'b0000;
            repeat (2) tick();
            reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                #3;
                chk("post_rst_sending", 32'(sending), 32'd0);
                chk("post_rst_serial", 32'(serial_out), 32'd0);
            end
        end else begin
            tick();
            done   = 4'b0000;
            ser_in = 4'b1111;
            #3;
            chk("gap_serial", 32'(serial_out), 32'd0);
            chk("gap_sending", 32'(sending), 32'd0);
            chk("gap_grant", 32'(grant), 32'd0);
            chk("gap_timeout", 32'(timeout_err), 32'(mode == 1));
            chk("gap_frame_start", 32'(frame_start), 32'd0);
            m_ptr = (id + 1) % N;
        end
    endtask

    // Bound on total run time in case the DUT or the bench stalls.
    initial begin
        #200000;
        $display("FAIL time_limit: run did not complete");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [N-1:0] ri;
        logic [N-1:0] rp;

        reset  = 1'b1;
        req    = 4'b0000;
        done   = 4'b0000;
        ser_in = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        chk("init_grant", 32'(grant), 32'd0);
        chk("init_grant_id", 32'(grant_id), 32'd0);
        chk("init_serial", 32'(serial_out), 32'd0);
        chk("init_sending", 32'(sending), 32'd0);
        chk("init_frame_start", 32'(frame_start), 32'd0);
        chk("init_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            chk("init_idle_sending", 32'(sending), 32'd0);
            chk("init_idle_serial", 32'(serial_out), 32'd0);
        end

        // Fairness with all channels requesting: 0,1,2,3,0.
        for (int f = 0; f < 5; f++) run_frame(4'b1111, 4'b1111, 8, 0, 1'b0, $urandom);

        // Single request with payload 1,0,1,1, spurious done lines, and req
        // dropped during the payload.
        run_frame(4'b0100, 4'b0000, 4, 0, 1'b1, 32'h0000_000D);

        // Wrap-around between channels 3 and 0.
        run_frame(4'b1001, 4'b1001, 3, 0, 1'b0, $urandom);
        run_frame(4'b1001, 4'b1001, 3, 0, 1'b0, $urandom);
        run_frame(4'b1001, 4'b1001, 3, 0, 1'b0, $urandom);

        // Randomized frames, including single-bit payloads.
        for (int r = 0; r < 8; r++) begin
            ri = 4'($urandom_range(1, 15));
            rp = 4'($urandom);
            run_frame(ri, rp, int'($urandom_range(1, 10)), 0, 1'($urandom_range(0, 1)), $urandom);
        end

`ifdef WATCHDOG_EN
        run_frame(4'b0010, 4'b0110, 16, 1, 1'b0, $urandom);
        run_frame(4'b0110, 4'b0000, 5, 0, 1'b0, $urandom);
        run_frame(4'b0010, 4'b0010, 10, 2, 1'b0, $urandom);
`else
        run_frame(4'b0010, 4'b0110, 40, 2, 1'b0, $urandom);
`endif

        // After reset the pointer restarts at channel 0.
        run_frame(4'b1111, 4'b0000, 2, 0, 1'b0, $urandom);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
